// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, DSIZE steps per operation.
// start/busy/done handshake; results stay registered until the next completion.
module seq_divider #(
  parameter int unsigned DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSIZE-1:0] dividend,
  input  logic [DSIZE-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] quotient,
  output logic [DSIZE-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(DSIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(DSIZE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  // Partial remainder kept at DSIZE bits: after every step it is below the divisor, so bit DSIZE is always zero.
  logic [DSIZE-1:0] r;
  logic [DSIZE-1:0] q;
  logic [DSIZE-1:0] d;
  logic [CW-1:0]    cnt;

  logic [DSIZE:0]   shifted;
  logic [DSIZE:0]   trial;
  logic             q_bit;
  logic [DSIZE-1:0] r_next;
  logic [DSIZE-1:0] q_next;
  logic             accept;

  always_comb begin
    shifted = {1'b0, r, q[DSIZE-1]};
    shifted = {r, q[DSIZE-1]};
    trial   = shifted - {1'b0, d};
    q_bit   = ~trial[DSIZE];
    r_next  = q_bit ? trial[DSIZE-1:0] : shifted[DSIZE-1:0];
    q_next  = {q[DSIZE-2:0], q_bit};
    accept  = start && (state != CALC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r           <= '0;
      q           <= dividend;
      d           <= divisor;
      cnt         <= '0;
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        // Divide by zero completes at the accepting edge without iterating.
        quotient  <= '1;
        remainder <= dividend;
        state     <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        state <= CALC;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= q_next;
            remainder <= r_next;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed quotients and remainders.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DSIZE(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for done, check latency, busy length and results.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez);
    int n;
    int bc;
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
    n = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    check({tag, "_lat"}, n, ez ? 0 : 16);
    check({tag, "_busy_cycles"}, bc, ez ? 0 : 16);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    tick();
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    logic held_ok;
    rst = 1'b0;
    start = 1'b1;
    dividend = 16'd100;
    divisor = 16'd7;
    tick();
    tick();
    check("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
    rst = 1'b1;
    start = 1'b0;
    tick();
    check("idle_after_reset", {busy, done}, 2'b00);

    run_op("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    run_op("div0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    run_op("max_by_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    run_op("small", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    run_op("max_by_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    run_op("zero_num", 16'd0, 16'd9, 16'd0, 16'd0, 1'b0);
    run_op("big", 16'd60000, 16'd257, 16'd233, 16'd119, 1'b0);

    // start pulses while busy must be dropped
    start = 1'b1;
    dividend = 16'd200;
    divisor = 16'd3;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 2 || n == 9) begin
        start = 1'b1;
        dividend = 16'd50;
        divisor = 16'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("busy_start_lat", n, 16);
    check("busy_start_q", quotient, 16'd66);
    check("busy_start_r", remainder, 16'd2);
    tick();
    tick();
    check("busy_start_idle", {busy, done}, 2'b00);
    check("busy_start_hold_q", quotient, 16'd66);

    // reset in the middle of CALC
    start = 1'b1;
    dividend = 16'd100;
    divisor = 16'd7;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
    tick();
    check("mid_reset_idle", {busy, done}, 2'b00);
    run_op("after_reset", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    // back-to-back: start held through the DONE cycle
    start = 1'b1;
    dividend = 16'd100;
    divisor = 16'd7;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("b2b_first_lat", n, 16);
    check("b2b_first_q", quotient, 16'd14);
    start = 1'b1;
    dividend = 16'd81;
    divisor = 16'd9;
    tick();
    start = 1'b0;
    check("b2b_accepted", {busy, done}, 2'b10);
    n = 0;
    held_ok = 1'b1;
    while (!done && n < 40) begin
      if (quotient !== 16'd14 || remainder !== 16'd2) held_ok = 1'b0;
      tick();
      n++;
    end
    check("b2b_held", held_ok, 1'b1);
    check("b2b_second_lat", n, 16);
    check("b2b_second_q", quotient, 16'd9);
    check("b2b_second_r", remainder, 16'd0);
    tick();
    check("b2b_end_idle", {busy, done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
